// File: rtl/snurisc_pkg.sv
// snurisc_pkg: shared loader state encoding, target codes and byte-lane count
package snurisc_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_TGT, ST_BASE, ST_CNT, ST_DATA, ST_DONE, ST_ERR} state_t;
   localparam logic [7:0] TGT_IMEM = 8'h00;
   localparam logic [7:0] TGT_DMEM = 8'h01;
   localparam logic [7:0] TGT_END = 8'hFF;
   localparam int LANES = 4;
endpackage

// File: rtl/snurisc_mem_loader_if.sv
// snurisc_mem_loader_if: host byte stream, memory write bus and loader status
// slave = loader side, master = host/memory side
interface snurisc_mem_loader_if #(parameter int ADDR_W = 14);
   logic i_start;
   logic i_byte_valid;
   logic [7:0] i_byte;
   logic o_byte_ready;
   logic o_mem_we;
   logic o_mem_sel;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic o_core_run;
   logic o_busy;
   logic o_err;
   modport slave (input i_start, i_byte_valid, i_byte,
                  output o_byte_ready, o_mem_we, o_mem_sel, o_mem_addr, o_mem_wdata, o_core_run, o_busy, o_err);
   modport master (output i_start, i_byte_valid, i_byte,
                   input o_byte_ready, o_mem_we, o_mem_sel, o_mem_addr, o_mem_wdata, o_core_run, o_busy, o_err);
endinterface

// File: rtl/snurisc_byte_packer.sv
// snurisc_byte_packer: little-endian byte-to-word assembler with registered word-ready pulse
// i_clr drops a partial word; o_last flags that the next accepted byte completes a word
module snurisc_byte_packer
   import snurisc_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_valid,
   input  logic [7:0] i_byte,
   output logic o_last,
   output logic o_ready,
   output logic [8*LANES-1:0] o_word
);
   logic [$clog2(LANES)-1:0] lane;
   logic [8*(LANES-1)-1:0] acc;
   assign o_last = lane == ($clog2(LANES))'(LANES-1);
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         lane <= '0;
         acc <= '0;
         o_ready <= 1'b0;
         o_word <= '0;
      end else begin
         o_ready <= i_valid & o_last & ~i_clr;
         if (i_clr) lane <= '0;
         else if (i_valid) begin
            lane <= o_last ? '0 : lane + 1'b1;
            acc <= {i_byte, acc[8*(LANES-1)-1:8]};
            if (o_last) o_word <= {i_byte, acc};
         end
      end
   end
endmodule

// File: rtl/snurisc_mem_loader.sv
// snurisc_mem_loader: streams sectioned host bytes into instruction/data memory, then releases the core
// i_clk/i_reset (async, active low); bus carries start, byte handshake, memory write bus and status
module snurisc_mem_loader #(
   parameter int ADDR_W = 14,
   parameter int TIMEOUT = 1024
) (
   input logic i_clk,
   input logic i_reset,
   snurisc_mem_loader_if.slave bus
);
   import snurisc_pkg::*;
   localparam int IW = $clog2(TIMEOUT + 1);
   state_t state, state_nx;
   logic busy, xfer, start_ld, hi, sel, last;
   logic [15:0] base, cnt, cnt_nx, idx;
   logic [16:0] span;
   logic [IW-1:0] idle;
   logic [ADDR_W-1:0] addr_q;
   assign busy = state inside {ST_TGT, ST_BASE, ST_CNT, ST_DATA};
   assign xfer = bus.i_byte_valid & busy;
   assign start_ld = bus.i_start & (state inside {ST_IDLE, ST_DONE, ST_ERR});
   assign cnt_nx = {bus.i_byte, cnt[7:0]};
   // one extra bit so a section ending exactly at the top of memory is legal
   assign span = {1'b0, base} + {1'b0, cnt_nx};
   assign bus.o_byte_ready = busy;
   assign bus.o_busy = busy;
   assign bus.o_core_run = state == ST_DONE;
   assign bus.o_err = state == ST_ERR;
   assign bus.o_mem_sel = sel;
   assign bus.o_mem_addr = addr_q;
   always_comb begin
      state_nx = state;
      if (start_ld) state_nx = ST_TGT;
      else if (busy && !xfer && idle == IW'(TIMEOUT - 1)) state_nx = ST_ERR;
      else if (xfer) begin
         case (state)
            ST_TGT:  state_nx = (bus.i_byte == TGT_IMEM || bus.i_byte == TGT_DMEM) ? ST_BASE :
                                bus.i_byte == TGT_END ? ST_DONE : ST_ERR;
            ST_BASE: state_nx = hi ? ST_CNT : ST_BASE;
            ST_CNT:  state_nx = !hi ? ST_CNT : span > (17'd1 << ADDR_W) ? ST_ERR :
                                cnt_nx == 16'd0 ? ST_TGT : ST_DATA;
            ST_DATA: state_nx = (last && idx == cnt - 16'd1) ? ST_TGT : ST_DATA;
            default: state_nx = state;
         endcase
      end
   end
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= ST_IDLE;
         hi <= 1'b0;
         sel <= 1'b0;
         base <= '0;
         cnt <= '0;
         idx <= '0;
         idle <= '0;
         addr_q <= '0;
      end else begin
         state <= state_nx;
         idle <= (!busy || xfer) ? '0 : idle + 1'b1;
         if (xfer) begin
            hi <= (state == ST_BASE || state == ST_CNT) ? ~hi : 1'b0;
            if (state == ST_TGT) sel <= bus.i_byte == TGT_DMEM;
            if (state == ST_BASE) base <= hi ? {bus.i_byte, base[7:0]} : {8'h00, bus.i_byte};
            if (state == ST_CNT) begin
               cnt <= hi ? cnt_nx : {8'h00, bus.i_byte};
               idx <= '0;
            end
            // address is latched with the final byte so it lines up with the write pulse
            if (state == ST_DATA && last) begin
               addr_q <= base[ADDR_W-1:0] + idx[ADDR_W-1:0];
               idx <= idx + 16'd1;
            end
         end
      end
   end
   snurisc_byte_packer u_packer (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_clr(start_ld),
      .i_valid(xfer && state == ST_DATA),
      .i_byte(bus.i_byte),
      .o_last(last),
      .o_ready(bus.o_mem_we),
      .o_word(bus.o_mem_wdata)
   );
endmodule

// File: tb/tb_snurisc_mem_loader.sv
// tb_snurisc_mem_loader: scoreboard bench for the memory loader
module tb_snurisc_mem_loader;
   localparam int AW = 14;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   logic [AW+32:0] exp_q[$];
   snurisc_mem_loader_if #(.ADDR_W(AW)) bus ();
   snurisc_mem_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.o_mem_we === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) chk("unexp_we", 1, 0);
         else chk("write", {bus.o_mem_sel, bus.o_mem_addr, bus.o_mem_wdata}, exp_q.pop_front());
      end
   end
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.i_byte_valid = 1'b1;
      bus.i_byte = b;
      @(posedge clk);
   endtask
   task automatic idle_for(input int n);
      @(negedge clk);
      bus.i_byte_valid = 1'b0;
      repeat (n) @(posedge clk);
   endtask
   task automatic start();
      @(negedge clk);
      bus.i_byte_valid = 1'b0;
      bus.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask
   task automatic hdr(input logic [7:0] tgt, input logic [15:0] base, input logic [15:0] cnt);
      send(tgt);
      send(base[7:0]);
      send(base[15:8]);
      send(cnt[7:0]);
      send(cnt[15:8]);
   endtask
   task automatic section(input logic sel, input logic [15:0] base, input logic [31:0] w[$]);
      hdr({7'd0, sel}, base, 16'(w.size()));
      foreach (w[i]) begin
         exp_q.push_back({sel, AW'(base + 16'(i)), w[i]});
         for (int k = 0; k < 4; k++) send(w[i][8*k+:8]);
      end
   endtask
   task automatic settle(input string tag, input logic run, input logic err);
      idle_for(3);
      @(negedge clk);
      chk({tag, "_run"}, bus.o_core_run, run);
      chk({tag, "_err"}, bus.o_err, err);
      chk({tag, "_pend"}, exp_q.size(), 0);
   endtask
   initial begin
      int w0;
      bus.i_start = 1'b0;
      bus.i_byte_valid = 1'b0;
      bus.i_byte = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_outs", {bus.o_byte_ready, bus.o_mem_we, bus.o_mem_sel, bus.o_core_run, bus.o_busy, bus.o_err}, 0);
      chk("rst_addr", bus.o_mem_addr, 0);
      chk("rst_wdata", bus.o_mem_wdata, 0);
      bus.i_start = 1'b1;
      rst_n = 1'b1;
      #1 chk("rel_busy", bus.o_busy, 0);
      @(posedge clk);
      #1 chk("first_busy", bus.o_busy, 1);
      chk("first_ready", bus.o_byte_ready, 1);
      @(negedge clk);
      bus.i_start = 1'b0;
      section(1'b0, 16'h0010, '{32'h00000013, 32'h00100093});
      send(8'hFF);
      settle("basic", 1, 0);
      chk("basic_wr", wr_cnt, 2);
      w0 = wr_cnt;
      start();
      chk("start_run", bus.o_core_run, 0);
      hdr(8'h01, 16'h0000, 16'h0000);
      send(8'hFF);
      settle("zero", 1, 0);
      chk("zero_wr", wr_cnt, w0);
      start();
      send(8'h05);
      @(negedge clk);
      chk("badtgt_err", bus.o_err, 1);
      chk("badtgt_rdy", bus.o_byte_ready, 0);
      start();
      chk("restart_busy", bus.o_busy, 1);
      send(8'hFF);
      settle("restart", 1, 0);
      start();
      hdr(8'h00, 16'h3FFF, 16'h0002);
      @(negedge clk);
      chk("ovf_err", bus.o_err, 1);
      settle("ovf", 0, 1);
      chk("ovf_wr", wr_cnt, w0);
      start();
      section(1'b1, 16'h3FFF, '{32'hCAFEF00D});
      send(8'hFF);
      settle("top", 1, 0);
      chk("top_wr", wr_cnt, w0 + 1);
      w0 = wr_cnt;
      start();
      hdr(8'h00, 16'h0040, 16'h0001);
      send(8'h11);
      send(8'h22);
      idle_for(TO - 1);
      @(negedge clk);
      chk("to_edge_err", bus.o_err, 0);
      @(posedge clk);
      @(negedge clk);
      chk("to_err", bus.o_err, 1);
      settle("to", 0, 1);
      chk("to_wr", wr_cnt, w0);
      start();
      hdr(8'h00, 16'h0040, 16'h0001);
      send(8'h11);
      send(8'h22);
      idle_for(TO - 1);
      exp_q.push_back({1'b0, AW'(16'h0040), 32'h44332211});
      send(8'h33);
      send(8'h44);
      send(8'hFF);
      settle("to_ok", 1, 0);
      chk("to_ok_wr", wr_cnt, w0 + 1);
      w0 = wr_cnt;
      start();
      hdr(8'h01, 16'h0100, 16'h0001);
      send(8'hAA);
      send(8'hBB);
      @(negedge clk);
      bus.i_byte_valid = 1'b0;
      rst_n = 1'b0;
      #1 chk("mid_rst_outs", {bus.o_byte_ready, bus.o_mem_we, bus.o_mem_sel, bus.o_core_run, bus.o_busy, bus.o_err}, 0);
      chk("mid_rst_addr", bus.o_mem_addr, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_wr", wr_cnt, w0);
      start();
      section(1'b1, 16'h0200, '{32'h01020304, 32'hA5A55A5A, 32'hFFFFFFFF});
      send(8'hFF);
      settle("fresh", 1, 0);
      chk("fresh_wr", wr_cnt, w0 + 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/snurisc_mem_loader.md
SNURISC_MEM_LOADER -- requirements
Module: snurisc_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 1024, max idle cycles between accepted bytes mid-load.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_start  input  1  begin load, sampled in IDLE, DONE, ERR.
REQ-006 SHALL have port i_byte_valid  input  1  host byte valid.
REQ-007 SHALL have port i_byte  input  8  host byte.
REQ-008 SHALL have port o_byte_ready  output  1  loader accepts byte; transfer = valid & ready.
REQ-009 SHALL have port o_mem_we  output  1  one-cycle memory write strobe.
REQ-010 SHALL have port o_mem_sel  output  1  0 = instruction memory, 1 = data memory.
REQ-011 SHALL have port o_mem_addr  output  ADDR_W  word address.
REQ-012 SHALL have port o_mem_wdata  output  32  write word.
REQ-013 SHALL have port o_core_run  output  1  releases core; high only in DONE.
REQ-014 SHALL have port o_busy  output  1  high in TGT, BASE, CNT, DATA.
REQ-015 SHALL have port o_err  output  1  high only in ERR.

Function
REQ-016 States SHALL be IDLE, TGT, BASE, CNT, DATA, DONE, ERR.
REQ-017 Stream format SHALL be sections {target byte, 2-byte LE base word address, 2-byte LE word count, count x 4-byte LE words}, ended by target 0xFF.
REQ-018 IDLE/DONE/ERR with i_start=1 SHALL go to TGT next cycle; o_core_run drops that same edge.
REQ-019 o_byte_ready SHALL be 1 in TGT, BASE, CNT, DATA and 0 otherwise, with no combinational path from i_byte_valid.
REQ-020 TGT: 0x00 -> sel=0, 0x01 -> sel=1, 0xFF -> DONE, any other value -> ERR.
REQ-021 BASE and CNT SHALL each consume exactly 2 bytes, low byte first.
REQ-022 After CNT, count 0 SHALL return to TGT; nonzero SHALL enter DATA.
REQ-023 DATA SHALL assemble 4 bytes little-endian (first byte = bits 7:0).
REQ-024 o_mem_we SHALL pulse exactly one cycle, the cycle after the 4th byte's transfer edge, with addr = base + word index and wdata = assembled word.
REQ-025 Byte acceptance SHALL continue without stall during the o_mem_we cycle (full throughput: one byte per cycle).
REQ-026 After the last word is accepted, state SHALL return to TGT; the final write pulse SHALL still issue.
REQ-027 If base + count > 2^ADDR_W (ADDR_W+1-bit compare), state SHALL go to ERR at the end of CNT, with no writes issued.
REQ-028 Idle counter SHALL reset on every transfer and in IDLE/DONE/ERR; reaching TIMEOUT consecutive no-transfer cycles in a busy state SHALL force ERR.
REQ-029 ERR and DONE SHALL be sticky until i_start or reset.
REQ-030 o_mem_addr and o_mem_wdata SHALL be don't-care when o_mem_we=0, but registered (glitch-free).

Reset
REQ-031 Reset assertion SHALL immediately force IDLE; all outputs 0; byte assembly, counters, and timeout cleared.
REQ-032 Reset mid-DATA SHALL abandon the partial word without any write pulse.
REQ-033 First transition out of IDLE SHALL occur no earlier than the first rising edge after reset release.

Structure
REQ-034 State encoding, the target codes (0x00, 0x01, 0xFF), and the byte-lane count SHALL live in shared package snurisc_pkg.
REQ-035 One sub-module, snurisc_byte_packer (4-byte LE assembler with word-ready pulse), SHALL be used; all other logic SHALL stay flat.

Verification
REQ-036 Reset release, i_start, stream 00 10 00 02 00 13 00 00 00 93 00 10 00 FF -> writes sel=0 at addr 0x0010 = 0x00000013 and 0x0011 = 0x00100093, then o_core_run=1.
REQ-037 Stream 01 00 00 00 00 FF (zero count) -> no writes, DONE.
REQ-038 Target byte 0x05 -> o_err=1, o_byte_ready=0, no writes; i_start -> TGT.
REQ-039 ADDR_W=14, base 0x3FFF, count 2 -> ERR, no writes; base 0x3FFF, count 1 -> single write at 0x3FFF.
REQ-040 Valid dropped for TIMEOUT cycles mid-DATA -> ERR; dropped for TIMEOUT-1 cycles then resumed -> normal completion.
REQ-041 Reset pulsed after 2 of 4 data bytes -> no o_mem_we, all outputs 0, and a fresh load succeeds.
